hd_saver: RTL and testbench

- Write-back counterpart of the HD program loader.
- On a store request, copies a fixed window of instruction/data memory back into the HD image slot selected by progIndex, so process state survives a context switch.
- Sits between the synchronous-read main memory and the HD write port.
- Its busy output stalls the core exactly the way the loader's busy output does.

---
 rtl/hd_pkg.sv | 21 ++
 rtl/hd_slot_calc.sv | 23 ++
 rtl/hd_saver.sv | 136 +++++++++++++
 tb/tb_hd_saver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// Shared HD slot layout and the saver state encoding.
package hd_pkg;

  localparam int HD_ADDR_W   = 12;
  localparam int MEM_ADDR_W  = 10;
  localparam int DATA_W      = 32;
  localparam int IDX_W       = 4;

  // Slot layout, shared with the loader so both agree on where a program lives
  localparam int SLOT_STRIDE = 300;
  localparam int SRC_BASE    = 512;
  localparam int XFER_LEN    = 300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COPY  = 2'd2,
    ST_DONE  = 2'd3
  } hd_state_e;

endpackage

// File: rtl/hd_slot_calc.sv
// Maps a program index to its HD slot base address and reports whether the
// whole transfer window fits inside the HD address space.
module hd_slot_calc
  import hd_pkg::*;
(
  input  logic [IDX_W-1:0]     prog_index,
  output logic [HD_ADDR_W-1:0] base_addr,
  output logic                 legal
);

  logic [15:0] base16;
  logic [16:0] end17;

  // Base is formed at 16 bits; the end check carries one extra bit so the
  // comparison against the address-space size cannot overflow.
  always_comb begin
    base16    = 16'(prog_index) * 16'(SLOT_STRIDE);
    end17     = {1'b0, base16} + 17'(XFER_LEN);
    legal     = (end17 <= 17'(1 << HD_ADDR_W));
    base_addr = base16[HD_ADDR_W-1:0];
  end

endmodule

// File: rtl/hd_saver.sv
// Writes a fixed window of main memory back into an HD program slot.
// Memory reads are synchronous, so one PRIME cycle fills the read pipeline
// before a gap-free run of XFER_LEN HD writes.
module hd_saver
  import hd_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      progIndex,
  input  logic                  storeFlag,
  input  logic                  loaderBusy,
  input  logic [DATA_W-1:0]     memReadData,
  output logic [MEM_ADDR_W-1:0] memReadAddr,
  output logic [HD_ADDR_W-1:0]  HDWriteAddr,
  output logic [DATA_W-1:0]     HDWriteData,
  output logic                  HDWriteEnable,
  output logic                  saving,
  output logic                  storeDone,
  output logic                  storeErr
);

  localparam int                    CNT_W      = $clog2(XFER_LEN);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(XFER_LEN - 1);
  localparam logic [MEM_ADDR_W-1:0] SRC_FIRST  = MEM_ADDR_W'(SRC_BASE);
  localparam logic [MEM_ADDR_W-1:0] SRC_SECOND = MEM_ADDR_W'(SRC_BASE + 1);
  localparam logic [MEM_ADDR_W-1:0] SRC_END    = MEM_ADDR_W'(SRC_BASE + XFER_LEN);

  hd_state_e               state_q, state_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [HD_ADDR_W-1:0]    hd_addr_q, hd_addr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [1:0]              low_q, low_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [HD_ADDR_W-1:0]    slot_base;
  logic                    slot_legal;

  hd_slot_calc u_slot_calc (
    .prog_index (progIndex),
    .base_addr  (slot_base),
    .legal      (slot_legal)
  );

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      hd_addr_q  <= '0;
      count_q    <= '0;
      low_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      hd_addr_q  <= hd_addr_d;
      count_q    <= count_d;
      low_q      <= low_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update; done/err are single-cycle pulses
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    hd_addr_d  = hd_addr_q;
    count_d    = count_q;
    low_d      = low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending request waits here while the loader owns the HD port
        if (storeFlag && !loaderBusy) begin
          if (slot_legal) begin
            mem_addr_d = SRC_FIRST;
            hd_addr_d  = slot_base;
            count_d    = '0;
            state_d    = ST_PRIME;
          end else begin
            err_d   = 1'b1;
            low_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_PRIME: begin
        mem_addr_d = SRC_SECOND;
        state_d    = ST_COPY;
      end
      ST_COPY: begin
        count_d   = count_q + 1'b1;
        hd_addr_d = hd_addr_q + 1'b1;
        // Read address parks one past the window instead of running ahead
        if (mem_addr_q != SRC_END) begin
          mem_addr_d = mem_addr_q + 1'b1;
        end
        if (count_q == CNT_LAST) begin
          done_d  = 1'b1;
          low_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Two consecutive low cycles of storeFlag re-arm; a held flag never does
        if (storeFlag) begin
          low_d = '0;
        end else if (low_q == 2'd1) begin
          low_d   = '0;
          state_d = ST_IDLE;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall is combinational so the core holds in the cycle it raises storeFlag
  always_comb begin
    saving = (state_q == ST_PRIME) || (state_q == ST_COPY) ||
             ((state_q == ST_IDLE) && storeFlag);
  end

  assign memReadAddr   = mem_addr_q;
  assign HDWriteAddr   = hd_addr_q;
  assign HDWriteData   = memReadData;
  assign HDWriteEnable = (state_q == ST_COPY);
  assign storeDone     = done_q;
  assign storeErr      = err_q;

endmodule

// File: tb/tb_hd_saver.sv
// Directed bench for hd_saver: models the synchronous-read memory and the HD
// image, then walks normal, held-flag, illegal, top-slot, loader-busy and
// reset-abort stores.
module tb_hd_saver;

  logic        clk;
  logic        rst_n;
  logic [3:0]  prog_idx;
  logic        store_flag;
  logic        loader_busy;
  logic [31:0] mem_rd_data;
  logic [9:0]  mem_rd_addr;
  logic [11:0] hd_wr_addr;
  logic [31:0] hd_wr_data;
  logic        hd_we;
  logic        saving;
  logic        store_done;
  logic        store_err;

  int n_vec;
  int n_bad;

  logic [31:0]  mem [1024];
  int unsigned  hd [4096];
  bit           hd_wr [4096];

  int cyc;
  int wr_cnt;
  int done_cnt;
  int err_cnt;
  int burst_start;
  int burst_last;
  int last_wr_addr;
  bit we_prev;

  hd_saver dut (
    .clock         (clk),
    .reset         (rst_n),
    .progIndex     (prog_idx),
    .storeFlag     (store_flag),
    .loaderBusy    (loader_busy),
    .memReadData   (mem_rd_data),
    .memReadAddr   (mem_rd_addr),
    .HDWriteAddr   (hd_wr_addr),
    .HDWriteData   (hd_wr_data),
    .HDWriteEnable (hd_we),
    .saving        (saving),
    .storeDone     (store_done),
    .storeErr      (store_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read main memory
  always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  // HD image and transfer monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (hd_we) begin
      if (!we_prev) burst_start = cyc;
      burst_last   = cyc;
      last_wr_addr = int'(hd_wr_addr);
      hd[hd_wr_addr]    = hd_wr_data;
      hd_wr[hd_wr_addr] = 1'b1;
      wr_cnt = wr_cnt + 1;
    end
    if (store_done) done_cnt = done_cnt + 1;
    if (store_err)  err_cnt  = err_cnt + 1;
    we_prev = hd_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for storeDone; leaves time 1 after the edge that raised it
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!store_done && n < 1000) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(store_done), 32'd1);
  endtask

  // count slot words whose data differs from mem[512+i]
  function automatic int slot_errs(input int base);
    int e;
    e = 0;
    for (int i = 0; i < 300; i++) begin
      if (!hd_wr[base + i] || hd[base + i] != 32'(i + 32'h100)) e++;
    end
    return e;
  endfunction

  initial begin
    int acc_cyc;
    int wr0;
    int done0;
    int err0;
    int bad;
    int n;
    int lo_wr;
    int hi_wr;

    n_vec = 0; n_bad = 0;
    cyc = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
    burst_start = 0; burst_last = 0; last_wr_addr = 0; we_prev = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = (i >= 512) ? 32'(i - 512 + 32'h100) : 32'(i);

    rst_n = 1'b0; prog_idx = 4'd0; store_flag = 1'b0; loader_busy = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_mem_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_hd_addr",  32'(hd_wr_addr),  32'd0);
    chk("rst_we",       32'(hd_we),       32'd0);
    chk("rst_saving",   32'(saving),      32'd0);
    chk("rst_done",     32'(store_done),  32'd0);
    chk("rst_err",      32'(store_err),   32'd0);
    rst_n = 1'b1;
    tick();

    // store to slot 2, flag held for 3 edges
    wr0 = wr_cnt; done0 = done_cnt;
    prog_idx = 4'd2; store_flag = 1'b1;
    #1;
    chk("s2_saving_comb", 32'(saving), 32'd1);
    tick();
    acc_cyc = cyc;
    chk("s2_prime_mem_addr", 32'(mem_rd_addr), 32'd512);
    chk("s2_prime_we", 32'(hd_we), 32'd0);
    tick();
    chk("s2_copy_we", 32'(hd_we), 32'd1);
    chk("s2_first_addr", 32'(hd_wr_addr), 32'd600);
    chk("s2_first_data", hd_wr_data, 32'h100);
    tick();
    store_flag = 1'b0;
    wait_done("s2");
    chk("s2_saving_at_done", 32'(saving), 32'd0);
    chk("s2_words", 32'(wr_cnt - wr0), 32'd300);
    chk("s2_first_lat", 32'(burst_start - acc_cyc), 32'd2);
    chk("s2_no_gaps", 32'(burst_last - burst_start + 1), 32'd300);
    chk("s2_last_addr", 32'(last_wr_addr), 32'd899);
    tick();
    chk("s2_done_pulse", 32'(store_done), 32'd0);
    chk("s2_done_cnt", 32'(done_cnt - done0), 32'd1);
    chk("s2_slot_data", 32'(slot_errs(600)), 32'd0);
    chk("s2_below_slot", 32'(hd_wr[599]), 32'd0);
    chk("s2_above_slot", 32'(hd_wr[900]), 32'd0);
    $display("store idx=2 base=600 words=%0d", wr_cnt - wr0);
    tick(); tick();

    // held flag: one transfer only, 1-cycle drop does not re-arm, 2-cycle drop does
    wr0 = wr_cnt;
    prog_idx = 4'd3; store_flag = 1'b1;
    wait_done("s3");
    for (int i = 0; i < 50; i++) tick();
    chk("s3_held_saving", 32'(saving), 32'd0);
    chk("s3_held_words", 32'(wr_cnt - wr0), 32'd300);
    store_flag = 1'b0;
    tick();
    store_flag = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("s3_drop1_words", 32'(wr_cnt - wr0), 32'd300);
    chk("s3_drop1_saving", 32'(saving), 32'd0);
    store_flag = 1'b0;
    tick(); tick();
    store_flag = 1'b1;
    #1;
    chk("s3_rearm_saving", 32'(saving), 32'd1);
    wait_done("s3b");
    chk("s3_second_words", 32'(wr_cnt - wr0), 32'd600);
    chk("s3_slot_data", 32'(slot_errs(900)), 32'd0);
    $display("store idx=3 base=900 words=%0d (two stores)", wr_cnt - wr0);
    store_flag = 1'b0;
    tick(); tick(); tick();

    // illegal index 13
    wr0 = wr_cnt; err0 = err_cnt;
    prog_idx = 4'd13; store_flag = 1'b1;
    tick();
    chk("s13_err", 32'(store_err), 32'd1);
    chk("s13_saving", 32'(saving), 32'd0);
    tick();
    chk("s13_err_pulse", 32'(store_err), 32'd0);
    store_flag = 1'b0;
    tick(); tick();
    chk("s13_no_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("s13_err_cnt", 32'(err_cnt - err0), 32'd1);
    $display("store idx=13 rejected errs=%0d", err_cnt - err0);

    // re-arm after the reject, into the top legal slot 12
    wr0 = wr_cnt;
    prog_idx = 4'd12; store_flag = 1'b1;
    wait_done("s12");
    chk("s12_words", 32'(wr_cnt - wr0), 32'd300);
    chk("s12_last_addr", 32'(last_wr_addr), 32'd3899);
    chk("s12_last_data", hd[3899], 32'h100 + 32'd299);
    chk("s12_slot_data", 32'(slot_errs(3600)), 32'd0);
    chk("s12_no_wrap", 32'(hd_wr[0]), 32'd0);
    $display("store idx=12 base=3600 words=%0d", wr_cnt - wr0);
    store_flag = 1'b0;
    tick(); tick(); tick();

    // loader busy holds the request pending
    wr0 = wr_cnt;
    prog_idx = 4'd1; loader_busy = 1'b1; store_flag = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (saving !== 1'b1 || hd_we !== 1'b0) bad++;
    end
    chk("busy_stall_cycles", 32'(bad), 32'd0);
    chk("busy_idle_addr", 32'(mem_rd_addr), 32'd812);
    loader_busy = 1'b0;
    tick();
    chk("busy_accept_mem", 32'(mem_rd_addr), 32'd512);
    chk("busy_accept_hd", 32'(hd_wr_addr), 32'd300);
    store_flag = 1'b0;
    wait_done("busy");
    chk("busy_slot_data", 32'(slot_errs(300)), 32'd0);
    $display("store idx=1 base=300 words=%0d after busy", wr_cnt - wr0);
    tick(); tick(); tick();

    // reset in the middle of a copy to slot 4
    done0 = done_cnt;
    prog_idx = 4'd4; store_flag = 1'b1;
    n = 0;
    while (!(hd_we && hd_wr_addr == 12'd1350) && n < 400) begin
      tick();
      n++;
    end
    chk("abort_reach_150", 32'(hd_wr_addr), 32'd1350);
    rst_n = 1'b0; store_flag = 1'b0;
    #1;
    chk("abort_we", 32'(hd_we), 32'd0);
    chk("abort_mem_addr", 32'(mem_rd_addr), 32'd0);
    chk("abort_hd_addr", 32'(hd_wr_addr), 32'd0);
    chk("abort_saving", 32'(saving), 32'd0);
    chk("abort_done", 32'(store_done), 32'd0);
    chk("abort_err", 32'(store_err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    lo_wr = 0; hi_wr = 0;
    for (int i = 1200; i < 1350; i++) if (hd_wr[i]) lo_wr++;
    for (int i = 1350; i < 1500; i++) if (hd_wr[i]) hi_wr++;
    chk("abort_partial", 32'(lo_wr), 32'd150);
    chk("abort_untouched", 32'(hi_wr), 32'd0);
    chk("abort_no_done", 32'(done_cnt - done0), 32'd0);
    $display("store idx=4 aborted after %0d words", lo_wr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
